// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Ports: clk, rst (async, active-high); start/funct3/rs1_data/rs2_data
//   from ID/EX; kill (flush), hold (downstream stall);
//   busy (stall request), result_valid, result (held until pipeline advances).
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            kill,
   input  logic            hold,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        fn_q, fn_d;
   logic              neg_q, neg_d;
   logic              negr_q, negr_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   res_q, res_d;

   logic              accept;
   logic              is_div;
   logic              sgn_a, sgn_b;
   logic              a_neg, b_neg;
   logic              div0, ovf, special;
   logic              last;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN-1:0]   spec_res;
   logic [XLEN:0]     mul_sum;
   logic [XLEN+1:0]   div_diff;
   logic [2*XLEN-1:0] acc_step;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;
   logic [XLEN-1:0]   fin_res;

   // Operand decode for the op presented in IDLE
   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      unique case (funct3)
         3'b001:  begin sgn_a = 1'b1; sgn_b = 1'b1; end
         3'b010:  begin sgn_a = 1'b1; end
         3'b100:  begin sgn_a = 1'b1; sgn_b = 1'b1; end
         3'b110:  begin sgn_a = 1'b1; sgn_b = 1'b1; end
         default: begin sgn_a = 1'b0; sgn_b = 1'b0; end
      endcase
      is_div  = funct3[2];
      a_neg   = sgn_a & rs1_data[XLEN-1];
      b_neg   = sgn_b & rs2_data[XLEN-1];
      a_mag   = a_neg ? -rs1_data : rs1_data;
      b_mag   = b_neg ? -rs2_data : rs2_data;
      div0    = (rs2_data == '0);
      ovf     = ~funct3[0] & (rs1_data == XMIN) & (rs2_data == '1);
      special = is_div & (div0 | ovf);
      if (div0) begin
         spec_res = funct3[1] ? rs1_data : '1;
      end else begin
         spec_res = funct3[1] ? '0 : XMIN;
      end
      accept = (state_q == S_IDLE) & start & ~kill;
      last   = (cnt_q == CNT_LAST);
   end

   // One iteration: shift-add multiply or restoring divide step.
   // acc holds {hi, lo}: product/remainder in hi, multiplier/quotient in lo.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
               + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
      if (fn_q[2]) begin
         if (div_diff[XLEN+1]) begin
            acc_step = {acc_q[2*XLEN-2:0], 1'b0};
         end else begin
            acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
         end
      end else begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end
      prod = neg_q ? -acc_step : acc_step;
      quo  = acc_step[XLEN-1:0];
      rem  = acc_step[2*XLEN-1:XLEN];
      unique case (fn_q)
         3'b000:  fin_res = prod[XLEN-1:0];
         3'b001,
         3'b010,
         3'b011:  fin_res = prod[2*XLEN-1:XLEN];
         3'b100,
         3'b101:  fin_res = neg_q ? -quo : quo;
         default: fin_res = negr_q ? -rem : rem;
      endcase
   end

   // Datapath register updates
   always_comb begin
      cnt_d  = cnt_q;
      fn_d   = fn_q;
      neg_d  = neg_q;
      negr_d = negr_q;
      opnd_d = opnd_q;
      acc_d  = acc_q;
      res_d  = res_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               fn_d   = funct3;
               neg_d  = a_neg ^ b_neg;
               negr_d = a_neg;
               cnt_d  = '0;
               if (special) begin
                  res_d = spec_res;
               end else begin
                  opnd_d = is_div ? b_mag : a_mag;
                  acc_d  = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
               end
            end
         end
         S_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (last && !kill) begin
               res_d = fin_res;
            end
         end
         default: begin
         end
      endcase
      if (kill) begin
         cnt_d = '0;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = special ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!hold) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (kill) begin
         state_d = S_IDLE;
      end
   end

   // Outputs
   always_comb begin
      busy = ~rst & ~kill
           & (((state_q == S_IDLE) & start) | (state_q == S_CALC));
      result_valid = (state_q == S_DONE);
      result       = res_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         fn_q   <= '0;
         neg_q  <= 1'b0;
         negr_q <= 1'b0;
         opnd_q <= '0;
         acc_q  <= '0;
         res_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         fn_q   <= fn_d;
         neg_q  <= neg_d;
         negr_q <= negr_d;
         opnd_q <= opnd_d;
         acc_q  <= acc_d;
         res_q  <= res_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized self-checking bench for ex_muldiv_unit.
// Results come from an arithmetic reference model of the RV32M rules.
module tb_ex_muldiv_unit;

   localparam logic [31:0] XMIN = 32'h8000_0000;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        kill;
   logic        hold;
   logic        busy;
   logic        result_valid;
   logic [31:0] result;

   int n_tests;
   int n_fail;
   logic [31:0] last_exp;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .funct3       (funct3),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .kill         (kill),
      .hold         (hold),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      logic [63:0] pv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f)
         3'b000: begin pv = 64'(ua * ub); return pv[31:0]; end
         3'b001: begin p = sa * sb; pv = 64'(p); return pv[63:32]; end
         3'b010: begin p = sa * ub; pv = 64'(p); return pv[63:32]; end
         3'b011: begin p = ua * ub; pv = 64'(p); return pv[63:32]; end
         3'b100: begin
            if (b == 0) return ONES;
            if (a == XMIN && b == ONES) return XMIN;
            p = sa / sb; pv = 64'(p); return pv[31:0];
         end
         3'b101: begin
            if (b == 0) return ONES;
            return a / b;
         end
         3'b110: begin
            if (b == 0) return a;
            if (a == XMIN && b == ONES) return 32'd0;
            p = sa % sb; pv = 64'(p); return pv[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return XMIN;
         2: return ONES;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   // Issue one op, wait for result, optionally hold it, then release.
   task automatic do_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input int holds);
      logic [31:0] exp;
      int exp_lat;
      int cyc;
      logic busy_bad;
      logic hold_bad;
      exp = ref_model(f, a, b);
      exp_lat = (f[2] && (b == 0 || (!f[0] && a == XMIN && b == ONES)))
              ? 1 : 33;
      @(negedge clk);
      start = 1'b1;
      funct3 = f;
      rs1_data = a;
      rs2_data = b;
      #1;
      check({tag, "_busy_acc"}, 32'(busy), 32'd1);
      cyc = 0;
      busy_bad = 1'b0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (!result_valid && !busy) busy_bad = 1'b1;
      end while (!result_valid && cyc < 64);
      check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      check({tag, "_busy_calc"}, 32'(busy_bad), 32'd0);
      check({tag, "_res"}, result, exp);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      hold_bad = 1'b0;
      for (int i = 0; i < holds; i++) begin
         hold = 1'b1;
         @(posedge clk);
         #1;
         if (!result_valid || result !== exp) hold_bad = 1'b1;
      end
      if (holds > 0) check({tag, "_hold"}, 32'(hold_bad), 32'd0);
      hold = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_idle"}, 32'(result_valid), 32'd0);
      last_exp = exp;
   endtask

   initial begin
      int seen;
      n_tests = 0;
      n_fail = 0;
      last_exp = 0;
      rst = 1'b0;
      start = 1'b0;
      funct3 = 3'b000;
      rs1_data = 0;
      rs2_data = 0;
      kill = 1'b0;
      hold = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 0);
      check("mul_val", last_exp, 32'hFFFF_FFEB);
      do_op("mulh", 3'b001, XMIN, XMIN, 0);
      do_op("mulhu", 3'b011, ONES, ONES, 0);
      do_op("mulhsu", 3'b010, ONES, 32'd2, 0);
      do_op("div", 3'b100, -32'sd7, 32'd2, 0);
      do_op("rem", 3'b110, -32'sd7, 32'd2, 0);
      do_op("divu", 3'b101, 32'd100, 32'd7, 0);
      do_op("remu", 3'b111, 32'd100, 32'd7, 0);
      do_op("div0", 3'b100, 32'd100, 32'd0, 0);
      do_op("rem0", 3'b110, 32'd100, 32'd0, 0);
      do_op("divovf", 3'b100, XMIN, ONES, 0);
      do_op("removf", 3'b110, XMIN, ONES, 0);
      do_op("hold3", 3'b000, 32'd12345, 32'd678, 3);

      // kill during CALC iteration 10
      @(negedge clk);
      start = 1'b1;
      funct3 = 3'b001;
      rs1_data = 32'h1234_5678;
      rs2_data = 32'h9ABC_DEF0;
      @(posedge clk);
      #1;
      repeat (10) @(posedge clk);
      #1;
      kill = 1'b1;
      #1;
      check("kill_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      kill = 1'b0;
      start = 1'b0;
      check("kill_valid", 32'(result_valid), 32'd0);
      check("kill_busy_idle", 32'(busy), 32'd0);
      check("kill_result_kept", result, last_exp);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (result_valid) seen++;
      end
      check("kill_no_valid", 32'(seen), 32'd0);

      // async reset mid-CALC
      @(negedge clk);
      start = 1'b1;
      funct3 = 3'b100;
      rs1_data = 32'd1000;
      rs2_data = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_valid", 32'(result_valid), 32'd0);
      check("arst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_op("divu_post", 3'b101, 32'd9, 32'd3, 0);

      for (int i = 0; i < 40; i++) begin
         do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)),
               rnd_op(), rnd_op(), int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched rs1/rs2 operands and funct3 of an M-extension instruction and computes the result over multiple cycles.
- Asserts busy so hazard logic can freeze PC, IF/ID and ID/EX while it works.
- Presents a held result to the EX/MEM path until the pipeline is able to advance.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  M-extension instruction valid in EX (from ID/EX decode)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  input  XLEN  operand A (dividend / multiplicand)
- rs2_data  input  XLEN  operand B (divisor / multiplier)
- kill  input  1  abort current operation (jb flush)
- hold  input  1  downstream stall (stall_cache); keeps result presented
- busy  output  1  stall request to hazard unit
- result_valid  output  1  result available this cycle
- result  output  XLEN  computed value

Behaviour:
- Reset: state IDLE, iteration counter 0, result 0, result_valid 0, internal operand/accumulator registers 0. busy is 0 in reset.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and kill=0 accepts the op. Latch funct3, sign flags, and absolute/unsigned operands per op.
  - Special divide cases go straight to DONE:
    - divisor 0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1.
    - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV result 0x80000000; REM result 0.
  - All other accepted ops go to CALC with counter=0.
- busy (combinational) = (IDLE & start & ~kill & ~special) | (IDLE & start & ~kill & special) | CALC. It is high in the accept cycle and in every CALC cycle. It is low in DONE and whenever kill=1.
- CALC: one iteration per cycle, XLEN cycles total; the counter increments each cycle.
  - Multiply: shift-add of magnitudes into a 2*XLEN accumulator.
  - Divide: restoring division of magnitudes, producing quotient and remainder.
  - On the last iteration (counter=XLEN-1), go to DONE and register the final result with sign correction:
    - Product negated if operand signs differ. MULH treats both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU and MUL use unsigned magnitudes.
    - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
    - Quotient negated if the signs differ (DIV). Remainder takes the sign of the dividend (REM).
- Latency:
  - Normal op accepted at cycle T: busy high T..T+XLEN, result_valid at T+XLEN+1 (T+33).
  - Special case: busy high at T only, result_valid at T+1.
- DONE:
  - result_valid=1 and result stable.
  - hold=1 stays in DONE.
  - hold=0 returns to IDLE next cycle.
  - start is ignored in DONE, because it is the same instruction still in EX; the next M instruction is sampled in IDLE.
- kill: any state goes to IDLE next cycle, with result_valid 0 and counter 0. kill overrides start and hold. result keeps its last value but is not valid.
- hold during CALC does not freeze iterations.
- Reset mid-operation: immediate return to reset values; no result_valid pulse.
- result changes only on entry to DONE.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD at cycle T -> busy T..T+32, result_valid at T+33, result=0xFFFFFFEB; IDLE at T+34 with hold=0.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each valid at T+33.
- Special cases, each with busy for one cycle and valid at T+1:
  - DIV 100/0 -> 0xFFFFFFFF; REM 100/0 -> 100.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- hold=1 for 3 cycles upon DONE -> result_valid and result stable for 4 cycles, IDLE afterwards. kill asserted at CALC iteration 10 -> IDLE next cycle, no result_valid.
- rst asserted asynchronously mid-CALC -> all outputs 0 immediately. A new DIVU 9/3 started after reset -> result 3 at T+33.
